// File: rtl/pwm_duty_encoder.sv
// pwm_duty_encoder: measures the high time of each 1024-clock PWM frame and
// quantizes it to the nearest 0..10 current code (inverse of the current
// decoder's code-to-reference mapping).
// Optional feature macro: PWM_ENC_CONFIRM_EN -- when defined, Corriente only
// follows a code seen at two consecutive frame ends; Medida updates every frame.
//
// Outputs are all registered. PWM is sampled directly; asynchronous sources
// must be synchronized before this block.
module pwm_duty_encoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       Habilitar,
    input  logic       PWM,
    output logic [3:0] Corriente,
    output logic [9:0] Medida,
    output logic       Valida
);

    // Decision points halfway between adjacent level centres, ties round up.
    localparam logic [9:0] THR [10] = '{10'd51,  10'd154, 10'd256, 10'd359, 10'd461,
                                        10'd563, 10'd666, 10'd768, 10'd871, 10'd973};

    logic [9:0]  frame_q;
    logic [10:0] acc_q;
    logic [3:0]  corr_q;
    logic [9:0]  med_q;
    logic        valida_q;

    logic [10:0] sum_d;
    logic [9:0]  sat_d;
    logic [3:0]  code_d;
    logic        frame_end;

`ifdef PWM_ENC_CONFIRM_EN
    logic [3:0]  cand_q;
    logic        cand_vld_q;
`endif

    // Running total including this cycle's sample, saturated and quantized.
    always_comb begin
        sum_d     = acc_q + {10'd0, PWM};
        sat_d     = sum_d[10] ? 10'd1023 : sum_d[9:0];
        frame_end = (frame_q == 10'd1023);
        code_d    = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (sat_d >= THR[i]) begin
                code_d = code_d + 4'd1;
            end
        end
    end

    // Frame counter, accumulator and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q    <= '0;
            acc_q      <= '0;
            corr_q     <= '0;
            med_q      <= '0;
            valida_q   <= 1'b0;
`ifdef PWM_ENC_CONFIRM_EN
            cand_q     <= '0;
            cand_vld_q <= 1'b0;
`endif
        end else if (!Habilitar) begin
            // Idle: partial frame discarded, reported values held.
            frame_q    <= '0;
            acc_q      <= '0;
            valida_q   <= 1'b0;
`ifdef PWM_ENC_CONFIRM_EN
            cand_q     <= '0;
            cand_vld_q <= 1'b0;
`endif
        end else begin
            valida_q <= 1'b0;
            if (frame_end) begin
                frame_q <= '0;
                acc_q   <= '0;
                med_q   <= sat_d;
`ifdef PWM_ENC_CONFIRM_EN
                // Candidate must be a real previous-frame code, so the first
                // frame after enable can never load Corriente on its own.
                cand_q     <= code_d;
                cand_vld_q <= 1'b1;
                if (cand_vld_q && (code_d == cand_q)) begin
                    corr_q   <= code_d;
                    valida_q <= 1'b1;
                end
`else
                corr_q   <= code_d;
                valida_q <= 1'b1;
`endif
            end else begin
                frame_q <= frame_q + 10'd1;
                acc_q   <= sum_d;
            end
        end
    end

    assign Corriente = corr_q;
    assign Medida    = med_q;
    assign Valida    = valida_q;

endmodule

// File: tb/tb_pwm_duty_encoder.sv
// Scoreboard bench for pwm_duty_encoder (default build, confirm feature off).
// The stimulus process pushes the hand-computed code, measurement and the
// cycle at which Valida must appear; the monitor pops on every Valida.
module tb_pwm_duty_encoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Habilitar = 1'b0;
    logic       PWM = 1'b0;
    logic [3:0] Corriente;
    logic [9:0] Medida;
    logic       Valida;

    typedef struct {
        logic [3:0]  code;
        logic [9:0]  meas;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    pwm_duty_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .Habilitar (Habilitar),
        .PWM       (PWM),
        .Corriente (Corriente),
        .Medida    (Medida),
        .Valida    (Valida)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every Valida must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (Valida === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valida", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("corriente", int'(Corriente), int'(e.code));
                    check("medida", int'(Medida), int'(e.meas));
                    check("valida_cycle", int'(cyc), int'(e.cyc));
                end
            end
        end
    end

    // One full enabled frame with n_high leading high cycles; optional release
    // of reset at the same point as frame cycle 0 is set up.
    task automatic run_frame(input int n_high, input logic [3:0] code,
                             input logic [9:0] meas, input bit rel_rst);
        exp_t e;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (rel_rst) reset = 1'b0;
                e.code = code;
                e.meas = meas;
                e.cyc  = cyc + 1 + 1023;
                exp_q.push_back(e);
            end
            Habilitar = 1'b1;
            PWM = (i < n_high);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_corriente", int'(Corriente), 0);
        check("rst_medida", int'(Medida), 0);
        check("rst_valida", int'(Valida), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Back-to-back frames: mid-scale, threshold edges, saturation, zero.
        run_frame(512,  4'd5,  10'd512,  1'b0);
        run_frame(512,  4'd5,  10'd512,  1'b0);
        run_frame(50,   4'd0,  10'd50,   1'b0);
        run_frame(51,   4'd1,  10'd51,   1'b0);
        run_frame(972,  4'd9,  10'd972,  1'b0);
        run_frame(1024, 4'd10, 10'd1023, 1'b0);
        run_frame(0,    4'd0,  10'd0,    1'b0);
        run_frame(102,  4'd1,  10'd102,  1'b0);
        run_frame(973,  4'd10, 10'd973,  1'b0);

        // Drop enable at frame cycle 600, re-enable 20 clocks later.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            PWM = 1'b1;
        end
        @(negedge clk);
        Habilitar = 1'b0;
        repeat (20) @(negedge clk);
        check("hold_corriente", int'(Corriente), 10);
        check("hold_medida", int'(Medida), 973);
        run_frame(205, 4'd2, 10'd205, 1'b0);

        // Reset mid-frame with PWM toggling: outputs clear without a clock edge.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            PWM = i[0];
        end
        #2;
        reset = 1'b1;
        #1;
        check("arst_corriente", int'(Corriente), 0);
        check("arst_medida", int'(Medida), 0);
        check("arst_valida", int'(Valida), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            PWM = i[0];
        end
        run_frame(410, 4'd4, 10'd410, 1'b1);

        repeat (5) @(negedge clk);
        check("pending_expectations", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
